// File: rtl/vx_cta_dispatch.sv
// CTA dispatcher: accepts one CTA request at a time, waits until enough
// warp slots are free, then spawns the CTA's warps one per cycle onto the
// lowest free slots. Slots are returned by warp-done notifications.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | ready for a new CTA request
// ST_WAIT  | CTA latched, waiting for free_count >= num_warps
// ST_SPAWN | issuing spawn commands, one warp per accepted handshake

module vx_cta_dispatch #(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_THREADS = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,

    input  logic                         i_req_valid,
    input  logic [31:0]                  i_req_num_warps,
    input  logic [31:0]                  i_req_start_pc,
    input  logic [31:0]                  i_req_param,
    input  logic [31:0]                  i_req_cta_x,
    input  logic [31:0]                  i_req_cta_y,
    input  logic [31:0]                  i_req_cta_z,
    input  logic [31:0]                  i_req_cta_id,
    input  logic [NUM_THREADS-1:0]       i_req_remain_mask,
    output logic                         o_req_ready,

    output logic                         o_spawn_valid,
    input  logic                         i_spawn_ready,
    output logic [$clog2(NUM_WARPS)-1:0] o_spawn_wid,
    output logic [31:0]                  o_spawn_pc,
    output logic [31:0]                  o_spawn_param,
    output logic [31:0]                  o_spawn_cta_id,
    output logic [31:0]                  o_spawn_cta_x,
    output logic [31:0]                  o_spawn_cta_y,
    output logic [31:0]                  o_spawn_cta_z,
    output logic [31:0]                  o_spawn_widx,
    output logic [NUM_THREADS-1:0]       o_spawn_tmask,

    input  logic                         i_done_valid,
    input  logic [$clog2(NUM_WARPS)-1:0] i_done_wid,

    output logic                         o_busy,
    output logic                         o_err_oversize,
    output logic [$clog2(NUM_WARPS):0]   o_free_count
);

    localparam int          WID_W    = $clog2(NUM_WARPS);
    localparam int          CNT_W    = WID_W + 1;
    localparam logic [31:0] MAX_WARP = 32'(NUM_WARPS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_SPAWN = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [NUM_WARPS-1:0]   r_free_mask;
    logic [NUM_WARPS-1:0]   w_free_mask_nxt;
    logic [CNT_W-1:0]       r_free_cnt;
    logic [CNT_W-1:0]       w_free_cnt_nxt;
    logic [CNT_W-1:0]       r_spawn_idx;
    logic [WID_W-1:0]       r_spawn_wid;
    logic [WID_W-1:0]       w_lowest_free;
    logic                   r_err_oversize;

    logic [31:0]            r_num_warps;
    logic [31:0]            r_start_pc;
    logic [31:0]            r_param;
    logic [31:0]            r_cta_x;
    logic [31:0]            r_cta_y;
    logic [31:0]            r_cta_z;
    logic [31:0]            r_cta_id;
    logic [NUM_THREADS-1:0] r_remain_mask;

    logic                   w_req_fire;
    logic                   w_spawn_fire;
    logic                   w_req_zero;
    logic                   w_req_oversize;
    logic                   w_fits;
    logic                   w_last_warp;
    logic                   w_done_eff;
    logic                   w_spawn_stall;
    logic [31:0]            w_idx_ext;
    logic [NUM_WARPS-1:0]   w_done_set;
    logic [NUM_WARPS-1:0]   w_spawn_clr;

    // Handshake and qualification terms shared by the FSM and datapath
    always_comb begin
        w_req_fire     = i_req_valid && o_req_ready;
        w_spawn_fire   = o_spawn_valid && i_spawn_ready;
        w_spawn_stall  = o_spawn_valid && !i_spawn_ready;
        w_req_zero     = (i_req_num_warps == 32'd0);
        w_req_oversize = (i_req_num_warps > MAX_WARP);
        w_idx_ext      = {{(32 - CNT_W){1'b0}}, r_spawn_idx};
        w_fits         = ({{(32 - CNT_W){1'b0}}, r_free_cnt} >= r_num_warps);
        w_last_warp    = ((w_idx_ext + 32'd1) == r_num_warps);
        // A done for a slot that is already free is a stray and is ignored.
        w_done_eff     = i_done_valid && !r_free_mask[i_done_wid];
    end

    // Next free mask / count: done releases and spawn allocations applied together
    always_comb begin
        w_done_set      = w_done_eff ? (NUM_WARPS'(1) << i_done_wid) : '0;
        w_spawn_clr     = w_spawn_fire ? (NUM_WARPS'(1) << r_spawn_wid) : '0;
        w_free_mask_nxt = (r_free_mask | w_done_set) & ~w_spawn_clr;
        w_free_cnt_nxt  = r_free_cnt + CNT_W'(w_done_eff) - CNT_W'(w_spawn_fire);
    end

    // Priority pick of the lowest free slot in the next-cycle mask
    always_comb begin
        w_lowest_free = '0;
        for (int i = NUM_WARPS - 1; i >= 0; i--) begin
            if (w_free_mask_nxt[i]) begin
                w_lowest_free = WID_W'(i);
            end
        end
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req_fire && !w_req_zero && !w_req_oversize) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_fits) begin
                    w_state_nxt = ST_SPAWN;
                end
            end
            ST_SPAWN: begin
                if (w_spawn_fire && w_last_warp) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: decoded from state and registers only, never from i_spawn_ready
    always_comb begin
        o_req_ready    = (r_state == ST_IDLE);
        o_spawn_valid  = (r_state == ST_SPAWN);
        o_spawn_wid    = r_spawn_wid;
        o_spawn_widx   = w_idx_ext;
        o_spawn_tmask  = w_last_warp ? r_remain_mask : {NUM_THREADS{1'b1}};
        o_spawn_pc     = r_start_pc;
        o_spawn_param  = r_param;
        o_spawn_cta_id = r_cta_id;
        o_spawn_cta_x  = r_cta_x;
        o_spawn_cta_y  = r_cta_y;
        o_spawn_cta_z  = r_cta_z;
        o_busy         = (r_state != ST_IDLE) || (r_free_mask != {NUM_WARPS{1'b1}});
        o_err_oversize = r_err_oversize;
        o_free_count   = r_free_cnt;
    end

    // Slot bookkeeping, spawn index and sticky oversize error
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_free_mask    <= {NUM_WARPS{1'b1}};
            r_free_cnt     <= CNT_W'(NUM_WARPS);
            r_spawn_idx    <= '0;
            r_spawn_wid    <= '0;
            r_err_oversize <= 1'b0;
        end else begin
            r_free_mask <= w_free_mask_nxt;
            r_free_cnt  <= w_free_cnt_nxt;
            if (w_req_fire) begin
                r_spawn_idx <= '0;
            end else if (w_spawn_fire) begin
                r_spawn_idx <= r_spawn_idx + CNT_W'(1);
            end
            // The offered slot is frozen while a spawn is stalled so the
            // payload cannot move under the scheduler, even if a lower slot
            // is released meanwhile.
            if (!w_spawn_stall) begin
                r_spawn_wid <= w_lowest_free;
            end
            if (w_req_fire && w_req_oversize) begin
                r_err_oversize <= 1'b1;
            end
        end
    end

    // Request payload capture; contents are only meaningful after acceptance
    always_ff @(posedge i_clk) begin
        if (w_req_fire) begin
            r_num_warps   <= i_req_num_warps;
            r_start_pc    <= i_req_start_pc;
            r_param       <= i_req_param;
            r_cta_x       <= i_req_cta_x;
            r_cta_y       <= i_req_cta_y;
            r_cta_z       <= i_req_cta_z;
            r_cta_id      <= i_req_cta_id;
            r_remain_mask <= i_req_remain_mask;
        end
    end

endmodule

// File: tb/tb_vx_cta_dispatch.sv
// Self-checking bench for vx_cta_dispatch: a slot-level reference model
// predicts every output each cycle, and directed scenarios pin the model with
// hand-computed spawn sequences before a long randomized run.

module tb_vx_cta_dispatch;

    localparam int NW = 4;
    localparam int NT = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic [31:0]   req_num = '0, req_pc = '0, req_param = '0;
    logic [31:0]   req_x = '0, req_y = '0, req_z = '0, req_id = '0;
    logic [NT-1:0] req_mask = '0;
    logic          spawn_ready = 1'b0;
    logic          done_valid = 1'b0;
    logic [1:0]    done_wid = '0;

    logic          req_ready, spawn_valid, busy, err_oversize;
    logic [1:0]    spawn_wid;
    logic [31:0]   spawn_pc, spawn_param, spawn_cta_id, spawn_widx;
    logic [31:0]   spawn_x, spawn_y, spawn_z;
    logic [NT-1:0] spawn_tmask;
    logic [2:0]    free_count;

    always #5 clk = ~clk;

    vx_cta_dispatch #(.NUM_WARPS(NW), .NUM_THREADS(NT)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .i_req_num_warps(req_num),
        .i_req_start_pc(req_pc), .i_req_param(req_param),
        .i_req_cta_x(req_x), .i_req_cta_y(req_y), .i_req_cta_z(req_z),
        .i_req_cta_id(req_id), .i_req_remain_mask(req_mask),
        .o_req_ready(req_ready),
        .o_spawn_valid(spawn_valid), .i_spawn_ready(spawn_ready),
        .o_spawn_wid(spawn_wid), .o_spawn_pc(spawn_pc),
        .o_spawn_param(spawn_param), .o_spawn_cta_id(spawn_cta_id),
        .o_spawn_cta_x(spawn_x), .o_spawn_cta_y(spawn_y), .o_spawn_cta_z(spawn_z),
        .o_spawn_widx(spawn_widx), .o_spawn_tmask(spawn_tmask),
        .i_done_valid(done_valid), .i_done_wid(done_wid),
        .o_busy(busy), .o_err_oversize(err_oversize), .o_free_count(free_count)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int log_wid[$], log_widx[$], log_tmask[$], log_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] lowest(input logic [NW-1:0] m);
        logic [1:0] r;
        r = '0;
        for (int i = NW - 1; i >= 0; i--) if (m[i]) r = 2'(i);
        return r;
    endfunction

    always @(posedge clk) cyc++;

    // ---------------- reference model (slot pool + current CTA) ----------------
    logic [NW-1:0] m_free;
    bit            m_active, m_spawning, m_err;
    int            m_idx, m_num;
    logic [NT-1:0] m_mask;
    logic [31:0]   m_pc, m_param, m_id;
    logic [1:0]    m_wid;

    always @(posedge clk or negedge rst_n) begin : model
        logic [NW-1:0] old_free;
        bit fire, was_sp, old_act;
        if (!rst_n) begin
            m_free = '1; m_active = 0; m_spawning = 0; m_err = 0;
            m_idx = 0; m_wid = '0;
        end else begin
            fire     = m_spawning && spawn_ready;
            was_sp   = m_spawning;
            old_act  = m_active;
            old_free = m_free;
            if (done_valid && !m_free[done_wid]) m_free[done_wid] = 1'b1;
            if (fire) m_free[m_wid] = 1'b0;
            if (m_active && !m_spawning && $countones(old_free) >= m_num) m_spawning = 1;
            if (fire) begin
                m_idx++;
                if (m_idx == m_num) begin
                    m_active = 0; m_spawning = 0;
                end
            end
            if (req_valid && !old_act) begin
                if (req_num > NW) m_err = 1;
                else if (req_num != 0) begin
                    m_active = 1; m_num = int'(req_num); m_idx = 0;
                    m_mask = req_mask; m_pc = req_pc; m_param = req_param; m_id = req_id;
                end
            end
            if (m_spawning && (!was_sp || fire)) m_wid = lowest(m_free);
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    bit         p_stall = 0;
    logic [1:0] p_wid;
    logic [31:0] p_widx;
    logic [NT-1:0] p_tmask;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("req_ready", 32'(req_ready), 32'(!m_active));
            chk("spawn_valid", 32'(spawn_valid), 32'(m_spawning));
            chk("busy", 32'(busy), 32'(m_active || m_free != '1));
            chk("err_oversize", 32'(err_oversize), 32'(m_err));
            chk("free_count", 32'(free_count), 32'($countones(m_free)));
            if (m_spawning && spawn_valid) begin
                chk("spawn_wid", 32'(spawn_wid), 32'(m_wid));
                chk("spawn_widx", spawn_widx, 32'(m_idx));
                chk("spawn_tmask", 32'(spawn_tmask),
                    32'((m_idx == m_num - 1) ? m_mask : {NT{1'b1}}));
                chk("spawn_pc", spawn_pc, m_pc);
                chk("spawn_param", spawn_param, m_param);
                chk("spawn_cta_id", spawn_cta_id, m_id);
            end
            if (p_stall && spawn_valid) begin
                chk("stall_wid", 32'(spawn_wid), 32'(p_wid));
                chk("stall_widx", spawn_widx, p_widx);
                chk("stall_tmask", 32'(spawn_tmask), 32'(p_tmask));
            end
            p_stall = spawn_valid && !spawn_ready;
            p_wid = spawn_wid; p_widx = spawn_widx; p_tmask = spawn_tmask;
            if (req_ready && req_valid) acc_cyc = cyc;
            if (spawn_valid && spawn_ready) begin
                log_wid.push_back(int'(spawn_wid));
                log_widx.push_back(int'(spawn_widx));
                log_tmask.push_back(int'(spawn_tmask));
                log_cyc.push_back(cyc);
            end
        end else begin
            p_stall = 0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst_n = 0; req_valid = 0; done_valid = 0; spawn_ready = 0;
        tick(2);
        rst_n = 1;
        tick(1);
    endtask

    task automatic send_cta(input int num, input logic [NT-1:0] mask, input logic [31:0] id);
        req_valid = 1; req_num = 32'(num); req_mask = mask;
        req_pc = 32'h8000_0000 + id * 16; req_param = 32'hA000_0000 ^ id; req_id = id;
        req_x = id; req_y = id + 1; req_z = id + 2;
        tick(1);
        req_valid = 0;
    endtask

    task automatic pulse_done(input int wid);
        done_valid = 1; done_wid = 2'(wid);
        tick(1);
        done_valid = 0;
    endtask

    task automatic wait_log(input int n, input int budget, input string nm);
        int k = 0;
        while (log_wid.size() < n && k < budget) begin tick(1); k++; end
        chk(nm, 32'(log_wid.size()), 32'(n));
    endtask

    initial begin
        int base, seen, exp_t[3];
        exp_t = '{15, 15, 3};

        do_reset();
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_free_count", 32'(free_count), 32'd4);
        chk("rst_err", 32'(err_oversize), 32'd0);

        // Three-warp CTA with ready held high: back-to-back on slots 0,1,2
        spawn_ready = 1;
        base = log_wid.size();
        send_cta(3, 4'b0011, 32'd1);
        wait_log(base + 3, 20, "cta3_count");
        if (log_wid.size() >= base + 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("cta3_wid", 32'(log_wid[base + i]), 32'(i));
                chk("cta3_widx", 32'(log_widx[base + i]), 32'(i));
                chk("cta3_tmask", 32'(log_tmask[base + i]), 32'(exp_t[i]));
            end
            chk("cta3_latency", 32'(log_cyc[base] - acc_cyc), 32'd2);
            chk("cta3_b2b", 32'(log_cyc[base + 2] - log_cyc[base]), 32'd2);
        end
        tick(1);
        chk("cta3_ready_after", 32'(req_ready), 32'd1);

        // Two-warp CTA with only slot 3 free waits until slot 1 is released
        base = log_wid.size();
        send_cta(2, 4'b1010, 32'd2);
        tick(5);
        chk("wait_no_spawn", 32'(log_wid.size()), 32'(base));
        chk("wait_req_ready", 32'(req_ready), 32'd0);
        pulse_done(1);
        wait_log(base + 2, 20, "cta2_count");
        if (log_wid.size() >= base + 2) begin
            chk("cta2_wid0", 32'(log_wid[base]), 32'd1);
            chk("cta2_wid1", 32'(log_wid[base + 1]), 32'd3);
            chk("cta2_tmask1", 32'(log_tmask[base + 1]), 32'hA);
        end
        for (int w = 0; w < NW; w++) pulse_done(w);
        chk("freed_all", 32'(free_count), 32'd4);

        // Oversize and empty CTAs are discarded
        base = log_wid.size();
        send_cta(5, 4'b1111, 32'd3);
        tick(4);
        chk("over_err", 32'(err_oversize), 32'd1);
        chk("over_ready", 32'(req_ready), 32'd1);
        send_cta(0, 4'b1111, 32'd4);
        tick(4);
        chk("empty_no_spawn", 32'(log_wid.size()), 32'(base));
        chk("empty_busy", 32'(busy), 32'd0);
        chk("err_sticky", 32'(err_oversize), 32'd1);
        do_reset();
        chk("err_cleared", 32'(err_oversize), 32'd0);

        // Four-warp CTA with a toggling scheduler
        base = log_wid.size();
        send_cta(4, 4'b0111, 32'd5);
        for (int k = 0; k < 80 && log_wid.size() < base + 4; k++) begin
            spawn_ready = 1'($urandom_range(0, 1));
            tick(1);
        end
        spawn_ready = 0;
        chk("cta4_count", 32'(log_wid.size()), 32'(base + 4));
        if (log_wid.size() >= base + 4) begin
            seen = 0;
            for (int i = 0; i < 4; i++) begin
                seen |= (1 << log_wid[base + i]);
                chk("cta4_widx", 32'(log_widx[base + i]), 32'(i));
            end
            chk("cta4_unique", 32'(seen), 32'hF);
        end
        tick(1);

        // Done for slot 2 in the same cycle slot 0 is spawned
        pulse_done(0);
        send_cta(1, 4'b0001, 32'd6);
        for (int k = 0; k < 10; k++) begin
            if (spawn_valid) begin
                spawn_ready = 1; done_valid = 1; done_wid = 2'd2;
                break;
            end
            tick(1);
        end
        tick(1);
        spawn_ready = 0; done_valid = 0;
        chk("coinc_free_count", 32'(free_count), 32'd1);
        chk("coinc_last_wid", 32'(log_wid[log_wid.size() - 1]), 32'd0);
        pulse_done(2);
        chk("stray_done", 32'(free_count), 32'd1);
        pulse_done(0); pulse_done(1); pulse_done(3);
        chk("freed_all2", 32'(free_count), 32'd4);

        // Reset in the middle of a CTA drops it and frees every slot
        base = log_wid.size();
        send_cta(3, 4'b0011, 32'd7);
        for (int k = 0; k < 10 && !spawn_valid; k++) tick(1);
        spawn_ready = 1;
        tick(1);
        spawn_ready = 0;
        chk("midrst_one_spawn", 32'(log_wid.size()), 32'(base + 1));
        rst_n = 0;
        #1;
        chk("midrst_valid", 32'(spawn_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        tick(2);
        rst_n = 1;
        tick(1);
        chk("midrst_free_count", 32'(free_count), 32'd4);
        chk("midrst_ready", 32'(req_ready), 32'd1);

        // Randomized traffic, checked cycle by cycle by the model
        for (int k = 0; k < 3000; k++) begin
            req_valid   = ($urandom_range(0, 3) == 0);
            req_num     = 32'($urandom_range(0, 5));
            req_mask    = NT'($urandom);
            req_pc      = $urandom; req_param = $urandom; req_id = $urandom;
            spawn_ready = ($urandom_range(0, 2) != 0);
            done_valid  = ($urandom_range(0, 2) == 0);
            done_wid    = 2'($urandom_range(0, NW - 1));
            tick(1);
        end
        req_valid = 0; spawn_ready = 1;
        for (int k = 0; k < 40; k++) begin
            done_valid = 1; done_wid = 2'(k % NW);
            tick(1);
        end
        done_valid = 0;
        tick(2);
        chk("drain_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vx_cta_dispatch.md
VX_CTA_DISPATCH -- requirements
Module: VX_cta_dispatch

Interface
REQ-001 SHALL have parameter NUM_WARPS, default `NUM_WARPS, number of hardware warp slots (power of 2, >=2).
REQ-002 SHALL have parameter NUM_THREADS, default `NUM_THREADS, threads per warp.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 kmu_bus_in  VX_kmu_bus_if.slave  --  CTA request receiver; fields below.
REQ-007 req_valid  input  1  CTA request present.
REQ-008 req_data.num_warps  input  32  warps in CTA.
REQ-009 req_data.start_pc, req_data.param  input  32 each  kernel PC, argument pointer.
REQ-010 req_data.cta_x/cta_y/cta_z/cta_id  input  32 each  CTA coordinates and linear ID.
REQ-011 req_data.remain_mask  input  NUM_THREADS  thread mask for last warp of CTA.
REQ-012 req_ready  output  1  request accepted when req_valid && req_ready.
REQ-013 spawn_valid  output  1  warp spawn command present.
REQ-014 spawn_ready  input  1  scheduler accepts spawn this cycle.
REQ-015 spawn_wid  output  log2(NUM_WARPS)  allocated warp slot.
REQ-016 spawn_pc, spawn_param, spawn_cta_id  output  32 each  copied from latched request.
REQ-017 spawn_widx  output  32  warp index within CTA, 0..num_warps-1.
REQ-018 spawn_tmask  output  NUM_THREADS  thread mask.
REQ-019 done_valid  input  1  a warp terminated; done_wid  input  log2(NUM_WARPS).
REQ-020 busy  output  1  high when FSM not IDLE or any warp slot allocated.
REQ-021 err_oversize  output  1  sticky: a CTA with num_warps > NUM_WARPS was received.

Function
REQ-022 SHALL implement FSM states IDLE, WAIT, SPAWN; req_ready = (state == IDLE), combinational from state only.
REQ-023 IDLE + handshake: latch all req_data fields, clear spawn index; num_warps==0 -> discard, stay IDLE; num_warps>NUM_WARPS -> discard, set err_oversize, stay IDLE; else -> WAIT.
REQ-024 SHALL keep a NUM_WARPS-bit free mask (1 = free) and a free-count register, width log2(NUM_WARPS)+1.
REQ-025 WAIT -> SPAWN when free_count >= latched num_warps (registered count; releases in cycle t count from t+1).
REQ-026 SPAWN: spawn_valid=1; spawn_wid = lowest-index free slot; spawn_widx = spawn index.
REQ-027 spawn_tmask = all ones for widx < num_warps-1; = latched remain_mask for widx == num_warps-1.
REQ-028 On spawn handshake: clear free bit of spawn_wid, increment spawn index; if last warp -> IDLE, else stay SPAWN.
REQ-029 spawn_valid SHALL stay high with stable payload until spawn_ready; no combinational path spawn_ready -> spawn_valid.
REQ-030 done_valid: set free bit of done_wid, free_count+1; done_wid already free -> ignored, no count change.
REQ-031 done_valid and spawn handshake same cycle (different wids): both applied, net free_count unchanged.
REQ-032 All warps of one CTA SHALL be spawned contiguously; CTAs spawned strictly in acceptance order.
REQ-033 Max rate: one spawn per cycle; first spawn no earlier than 2 cycles after request handshake.

Reset
REQ-034 reset low -> state IDLE, free mask all ones, free_count=NUM_WARPS, spawn index 0, err_oversize 0, spawn_valid 0, busy 0, req_ready 1 after release; latched payload registers not reset.
REQ-035 reset mid-SPAWN/WAIT SHALL drop the in-flight CTA and release all warp slots.

Verification (NUM_WARPS=4, NUM_THREADS=4)
REQ-036 CTA num_warps=3, remain_mask=4'b0011, spawn_ready=1 -> wids 0,1,2, widx 0,1,2, tmasks 1111,1111,0011, back-to-back; req_ready high after last.
REQ-037 Slots 0-2 busy, CTA num_warps=2 -> stays WAIT, req_ready=0; done_wid=1 -> wids 1,3 spawned.
REQ-038 num_warps=5 -> req_ready stays 1, no spawn, err_oversize=1 until reset; num_warps=0 -> no spawn, no error.
REQ-039 spawn_ready toggled 0/1 during 4-warp CTA -> payload stable while stalled, exactly 4 spawns, no duplicate wid.
REQ-040 done for slot 2 coincident with spawn of slot 0 -> both applied; done for already-free slot -> free_count unchanged.
REQ-041 reset asserted mid-SPAWN after 1 of 3 warps -> spawn_valid 0 immediately, busy 0, free_count=4 after release.
